ddr3_wr_issue: RTL and testbench
================================

DDR3_WR_ISSUE -- requirements
Module: ddr3_wr_issue

Interface
REQ-001 Parameter ADDRS, 32, byte-address width.
REQ-002 Parameter WIDTH, 32, data-beat width; MASKS, WIDTH/8, strobe width.
REQ-003 Parameter AXI_ID_WIDTH, 4, write-ID width.
REQ-004 Port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports mem_store_i in 1 / mem_accept_o out 1 / mem_wseq_i in 1 / mem_wrid_i in AXI_ID_WIDTH / mem_addr_i in ADDRS: BL8 write-command port from the write-datapath FIFO.
REQ-007 Ports mem_valid_i in 1 / mem_ready_o out 1 / mem_last_i in 1 / mem_strb_i in MASKS / mem_data_i in WIDTH: write-data beat stream.
REQ-008 Ports ddr_req_o out 1 / ddr_ack_i in 1 / ddr_addr_o out ADDRS / ddr_wrid_o out AXI_ID_WIDTH / ddr_seq_o out 1 / ddr_last_o out 1: write request to the DDR3 command FSM.
REQ-009 Ports ddr_wnext_i in 1 / ddr_wdata_o out WIDTH / ddr_wstrb_o out MASKS: controller-paced write-data pull port.
REQ-010 Port err_o  out  1  sticky protocol-error flag.

Function
REQ-011 One BL8 command = exactly 4 data beats (BURST_BEATS = 4).
REQ-012 FSM states ST_IDLE, ST_FILL, ST_REQ, ST_DRAIN; single 4-entry beat buffer.
REQ-013 ST_IDLE: mem_accept_o = mem_store_i (combinational); on store&accept capture addr/wrid/wseq, clear beat counter, go ST_FILL.
REQ-014 ST_FILL: mem_ready_o = 1; each mem_valid_i&mem_ready_o writes {strb,data} to buffer[wcnt], wcnt += 1; 4th beat goes ST_REQ.
REQ-015 ddr_last_o = OR of mem_last_i over the 4 captured beats.
REQ-016 ST_REQ: ddr_req_o = 1, held with stable addr/wrid/seq/last until ddr_ack_i; ack goes ST_DRAIN.
REQ-017 ST_DRAIN: ddr_wdata_o/ddr_wstrb_o = buffer[rcnt] (combinational); each ddr_wnext_i advances rcnt; 4th wnext goes ST_IDLE.
REQ-018 mem_accept_o = 0 and mem_ready_o = 0 outside ST_IDLE/ST_FILL respectively; no data accepted before a command.
REQ-019 Minimum latency: command accepted cycle N, beats N+1..N+4 -> ddr_req_o high at N+5; one idle bubble between drain end and next accept.
REQ-020 ddr_wnext_i outside ST_DRAIN ignored; ddr_ack_i outside ST_REQ ignored.
REQ-021 Counters 2 bits, wrap 3->0 exactly on state exit.
REQ-022 err_o set (sticky) if: mem_last_i on beat index 0-2; captured mem_addr_i[3:0] != 0; ddr_wnext_i asserted in ST_DRAIN beyond 4 beats (cannot occur, checked by counter); operation otherwise unaffected.
REQ-023 ddr_wdata_o/ddr_wstrb_o outside ST_DRAIN: hold last value (don't-care to consumer).

Reset
REQ-024 reset: state ST_IDLE, counters 0, ddr_req_o 0, ddr_last_o 0, ddr_seq_o 0, err_o 0, mem_ready_o 0; buffer contents not reset.
REQ-025 reset mid-FILL/REQ/DRAIN discards buffered beats and pending request; mem_accept_o 0 during reset cycle.

Structure
REQ-026 Shared package/include: BURST_BEATS, ST_* encodings, AXI_RESP codes.
REQ-027 One sub-module bl8_beat_buf: 4x(MASKS+WIDTH) register file, write index/enable, read index, async read.

Verification
REQ-028 cmd addr 0x100, id 3, 4 beats 0xA0..0xA3, last on beat 3, ack immediate -> ddr_req at N+5, addr 0x100, wrid 3, ddr_last 1, drain order A0..A3.
REQ-029 awlen=15 split into 4 cmds (seq 0,1,1,1), continuous data -> 4 requests, ddr_seq 0,1,1,1, ddr_last only on 4th.
REQ-030 ddr_ack delayed 10 cycles, wnext every other cycle -> req held stable 10 cycles, mem_accept 0 throughout, data correct.
REQ-031 mem_last on beat 1, or addr 0x104 -> err_o 1 next cycle, stays 1 until reset, burst still completes.
REQ-032 reset asserted after 2 FILL beats -> ST_IDLE, next 4-beat burst drains only its own data.

Source files
------------

// File: rtl/ddr3_wr_issue_pkg.sv
// Shared definitions for the DDR3 BL8 write-issue block.
// Holds the burst geometry, FSM state encodings, AXI response codes and a
// small alignment helper used by the issue FSM.
package ddr3_wr_issue_pkg;

  localparam int unsigned BURST_BEATS = 4;
  localparam int unsigned CNT_W       = $clog2(BURST_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // A BL8 of 4 x 32-bit beats covers 16 bytes, so commands must be 16-byte aligned.
  function automatic logic addr_misaligned(input logic [3:0] addr_lo);
    return addr_lo != 4'h0;
  endfunction

endpackage

// File: rtl/ddr3_wr_issue_beat_buf.sv
// bl8_beat_buf: 4-entry {strobe, data} register file for one BL8 burst.
// Ports: clock; wr_en/wr_idx/wr_strb/wr_data write side (registered);
// rd_idx/rd_strb/rd_data read side (asynchronous). Contents are not reset.
module bl8_beat_buf
  import ddr3_wr_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MASKS = WIDTH / 8
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [MASKS-1:0] wr_strb,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0] rd_idx,
  output logic [MASKS-1:0] rd_strb,
  output logic [WIDTH-1:0] rd_data
);

  logic [MASKS+WIDTH-1:0] mem_q [BURST_BEATS];

  // Beat storage; data path only, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= {wr_strb, wr_data};
    end
  end

  assign {rd_strb, rd_data} = mem_q[rd_idx];

endmodule

// File: rtl/ddr3_wr_issue.sv
// ddr3_wr_issue: collects one BL8 write command plus its 4 data beats, then
// issues a single request to the DDR3 command FSM and lets the controller
// pull the buffered beats.
// Ports: clock/reset (sync, active-high); mem_store_i/mem_accept_o command
// port; mem_valid_i/mem_ready_o beat port; ddr_req_o/ddr_ack_i request
// handshake with addr/wrid/seq/last; ddr_wnext_i/ddr_wdata_o/ddr_wstrb_o
// data pull; err_o sticky protocol error.
module ddr3_wr_issue
  import ddr3_wr_issue_pkg::*;
#(
  parameter int unsigned ADDRS        = 32,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MASKS        = WIDTH / 8,
  parameter int unsigned AXI_ID_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_store_i,
  output logic                    mem_accept_o,
  input  logic                    mem_wseq_i,
  input  logic [AXI_ID_WIDTH-1:0] mem_wrid_i,
  input  logic [ADDRS-1:0]        mem_addr_i,
  input  logic                    mem_valid_i,
  output logic                    mem_ready_o,
  input  logic                    mem_last_i,
  input  logic [MASKS-1:0]        mem_strb_i,
  input  logic [WIDTH-1:0]        mem_data_i,
  output logic                    ddr_req_o,
  input  logic                    ddr_ack_i,
  output logic [ADDRS-1:0]        ddr_addr_o,
  output logic [AXI_ID_WIDTH-1:0] ddr_wrid_o,
  output logic                    ddr_seq_o,
  output logic                    ddr_last_o,
  input  logic                    ddr_wnext_i,
  output logic [WIDTH-1:0]        ddr_wdata_o,
  output logic [MASKS-1:0]        ddr_wstrb_o,
  output logic                    err_o
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]        rcnt_q, rcnt_d;
  logic [ADDRS-1:0]        addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0] wrid_q, wrid_d;
  logic                    seq_q, seq_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic                    buf_we;

  bl8_beat_buf #(
    .WIDTH (WIDTH),
    .MASKS (MASKS)
  ) u_buf (
    .clock   (clock),
    .wr_en   (buf_we),
    .wr_idx  (wcnt_q),
    .wr_strb (mem_strb_i),
    .wr_data (mem_data_i),
    .rd_idx  (rcnt_q),
    .rd_strb (ddr_wstrb_o),
    .rd_data (ddr_wdata_o)
  );

  // State and command registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      addr_q  <= '0;
      wrid_q  <= '0;
      seq_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      addr_q  <= addr_d;
      wrid_q  <= wrid_d;
      seq_q   <= seq_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state, handshakes and error detection.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    addr_d       = addr_q;
    wrid_d       = wrid_q;
    seq_d        = seq_q;
    last_d       = last_q;
    err_d        = err_q;
    mem_accept_o = 1'b0;
    mem_ready_o  = 1'b0;
    buf_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        mem_accept_o = mem_store_i;
        if (mem_store_i) begin
          addr_d  = mem_addr_i;
          wrid_d  = mem_wrid_i;
          seq_d   = mem_wseq_i;
          last_d  = 1'b0;
          wcnt_d  = '0;
          err_d   = err_q | addr_misaligned(mem_addr_i[3:0]);
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_ready_o = 1'b1;
        if (mem_valid_i) begin
          buf_we = 1'b1;
          last_d = last_q | mem_last_i;
          // A last marker is only legal on the final beat of the burst.
          err_d  = err_q | (mem_last_i & (wcnt_q != LAST_BEAT));
          wcnt_d = CNT_W'(wcnt_q + 1'b1);
          if (wcnt_q == LAST_BEAT) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (ddr_ack_i) begin
          rcnt_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Exit on the 4th pull, so an over-pull can never reach the counter.
        if (ddr_wnext_i) begin
          rcnt_d = CNT_W'(rcnt_q + 1'b1);
          if (rcnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Nothing is taken in during the reset cycle.
    if (reset) begin
      mem_accept_o = 1'b0;
      mem_ready_o  = 1'b0;
      buf_we       = 1'b0;
    end
  end

  assign ddr_req_o  = (state_q == ST_REQ);
  assign ddr_addr_o = addr_q;
  assign ddr_wrid_o = wrid_q;
  assign ddr_seq_o  = seq_q;
  assign ddr_last_o = last_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ddr3_wr_issue.sv
module tb_ddr3_wr_issue;

  localparam int unsigned ADDRS = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned MASKS = WIDTH / 8;
  localparam int unsigned IDW   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             mem_store_i, mem_accept_o, mem_wseq_i;
  logic [IDW-1:0]   mem_wrid_i;
  logic [ADDRS-1:0] mem_addr_i;
  logic             mem_valid_i, mem_ready_o, mem_last_i;
  logic [MASKS-1:0] mem_strb_i;
  logic [WIDTH-1:0] mem_data_i;
  logic             ddr_req_o, ddr_ack_i;
  logic [ADDRS-1:0] ddr_addr_o;
  logic [IDW-1:0]   ddr_wrid_o;
  logic             ddr_seq_o, ddr_last_o, ddr_wnext_i;
  logic [WIDTH-1:0] ddr_wdata_o;
  logic [MASKS-1:0] ddr_wstrb_o;
  logic             err_o;

  always #5 clock = ~clock;

  ddr3_wr_issue #(
    .ADDRS(ADDRS), .WIDTH(WIDTH), .MASKS(MASKS), .AXI_ID_WIDTH(IDW)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_store_i(mem_store_i), .mem_accept_o(mem_accept_o), .mem_wseq_i(mem_wseq_i),
    .mem_wrid_i(mem_wrid_i), .mem_addr_i(mem_addr_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_last_i(mem_last_i),
    .mem_strb_i(mem_strb_i), .mem_data_i(mem_data_i),
    .ddr_req_o(ddr_req_o), .ddr_ack_i(ddr_ack_i), .ddr_addr_o(ddr_addr_o),
    .ddr_wrid_o(ddr_wrid_o), .ddr_seq_o(ddr_seq_o), .ddr_last_o(ddr_last_o),
    .ddr_wnext_i(ddr_wnext_i), .ddr_wdata_o(ddr_wdata_o), .ddr_wstrb_o(ddr_wstrb_o),
    .err_o(err_o)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Reference model state: sticky error and the beats of the current burst.
  bit               err_m = 1'b0;
  logic [WIDTH-1:0] exp_data [4];
  logic [MASKS-1:0] exp_strb [4];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    mem_store_i = 1'b0; mem_wseq_i = 1'b0; mem_wrid_i = '0; mem_addr_i = '0;
    mem_valid_i = 1'b0; mem_last_i = 1'b0; mem_strb_i = '0; mem_data_i = '0;
    ddr_ack_i   = 1'b0; ddr_wnext_i = 1'b0;
  endtask

  // One complete command: accept, 4 beats, request wait, controller pull.
  task automatic run_burst(input logic [ADDRS-1:0] addr, input logic [IDW-1:0] id,
                           input bit seq, input logic [3:0] last_mask,
                           input logic [WIDTH-1:0] base, input int ack_delay,
                           input int wnext_gap, input bit fill_gaps);
    int acc_cyc;
    int gaps = 0;
    for (int i = 0; i < 4; i++) begin
      exp_data[i] = base + WIDTH'(i);
      exp_strb[i] = MASKS'($urandom);
    end

    @(negedge clock); drive_idle();
    mem_store_i = 1'b1; mem_addr_i = addr; mem_wrid_i = id; mem_wseq_i = seq;
    #1;
    check_eq("accept_idle", 64'(mem_accept_o), 64'd1);
    check_eq("ready_idle", 64'(mem_ready_o), 64'd0);
    check_eq("req_idle", 64'(ddr_req_o), 64'd0);
    acc_cyc = cyc;
    if (addr[3:0] != 4'h0) err_m = 1'b1;

    for (int i = 0; i < 4; i++) begin
      if (fill_gaps && $urandom_range(0, 1) == 1) begin
        @(negedge clock); drive_idle();
        ddr_ack_i = 1'b1; ddr_wnext_i = 1'b1;
        gaps++;
        #1 check_eq("ready_gap", 64'(mem_ready_o), 64'd1);
      end
      @(negedge clock); drive_idle();
      mem_valid_i = 1'b1; mem_data_i = exp_data[i]; mem_strb_i = exp_strb[i];
      mem_last_i = last_mask[i]; mem_store_i = 1'b1;
      #1;
      check_eq("ready_fill", 64'(mem_ready_o), 64'd1);
      check_eq("accept_fill", 64'(mem_accept_o), 64'd0);
      check_eq("req_fill", 64'(ddr_req_o), 64'd0);
      check_eq("err_fill", 64'(err_o), 64'(err_m));
      if (last_mask[i] && i < 3) err_m = 1'b1;
    end

    for (int k = 0; k <= ack_delay; k++) begin
      @(negedge clock); drive_idle();
      mem_store_i = 1'b1; mem_addr_i = ADDRS'($urandom);
      ddr_wnext_i = 1'($urandom_range(0, 1));
      ddr_ack_i   = (k == ack_delay);
      #1;
      if (k == 0) check_eq("req_latency", 64'(cyc - acc_cyc), 64'(5 + gaps));
      check_eq("req_held", 64'(ddr_req_o), 64'd1);
      check_eq("req_addr", 64'(ddr_addr_o), 64'(addr));
      check_eq("req_wrid", 64'(ddr_wrid_o), 64'(id));
      check_eq("req_seq", 64'(ddr_seq_o), 64'(seq));
      check_eq("req_last", 64'(ddr_last_o), 64'(|last_mask));
      check_eq("accept_req", 64'(mem_accept_o), 64'd0);
      check_eq("ready_req", 64'(mem_ready_o), 64'd0);
      check_eq("err_req", 64'(err_o), 64'(err_m));
    end

    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < wnext_gap; g++) begin
        @(negedge clock); drive_idle(); mem_store_i = 1'b1;
        #1;
        check_eq("drain_wait_data", 64'(ddr_wdata_o), 64'(exp_data[i]));
        check_eq("accept_drain", 64'(mem_accept_o), 64'd0);
      end
      @(negedge clock); drive_idle(); mem_store_i = 1'b1; ddr_wnext_i = 1'b1;
      #1;
      check_eq("drain_data", 64'(ddr_wdata_o), 64'(exp_data[i]));
      check_eq("drain_strb", 64'(ddr_wstrb_o), 64'(exp_strb[i]));
      check_eq("req_drain", 64'(ddr_req_o), 64'd0);
      check_eq("accept_drain", 64'(mem_accept_o), 64'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock); drive_idle();
    reset = 1'b1; mem_store_i = 1'b1; mem_valid_i = 1'b1;
    #1;
    check_eq("accept_in_reset", 64'(mem_accept_o), 64'd0);
    check_eq("ready_in_reset", 64'(mem_ready_o), 64'd0);
    @(negedge clock); drive_idle(); reset = 1'b0;
    err_m = 1'b0;
    #1;
    check_eq("rst_req", 64'(ddr_req_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_last", 64'(ddr_last_o), 64'd0);
    check_eq("rst_seq", 64'(ddr_seq_o), 64'd0);
    check_eq("rst_ready", 64'(mem_ready_o), 64'd0);
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    mem_store_i = 1'b1;
    @(negedge clock);
    #1;
    check_eq("init_accept", 64'(mem_accept_o), 64'd0);
    check_eq("init_req", 64'(ddr_req_o), 64'd0);
    check_eq("init_err", 64'(err_o), 64'd0);
    check_eq("init_last", 64'(ddr_last_o), 64'd0);
    check_eq("init_seq", 64'(ddr_seq_o), 64'd0);
    check_eq("init_ready", 64'(mem_ready_o), 64'd0);
    @(negedge clock); drive_idle(); reset = 1'b0;

    // Basic command with immediate ack.
    run_burst(32'h100, 4'd3, 1'b0, 4'b1000, 32'hA0, 0, 0, 1'b0);

    // awlen=15 split into four back-to-back commands.
    for (int k = 0; k < 4; k++)
      run_burst(32'h1000 + 32'(k * 16), 4'd7, k != 0, (k == 3) ? 4'b1000 : 4'b0000,
                32'h5000 + 32'(k * 16), 0, 0, 1'b0);

    // Slow ack, controller pulls every other cycle.
    run_burst(32'h2000, 4'd9, 1'b0, 4'b1000, 32'h3000, 10, 1, 1'b0);

    // Random clean traffic.
    for (int r = 0; r < 8; r++)
      run_burst($urandom & 32'hFFFF_FFF0, IDW'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'b0000, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);

    // Early last marker: error is raised, stays sticky, burst completes.
    run_burst(32'h3000, 4'd1, 1'b0, 4'b0010, 32'h7700, 1, 0, 1'b0);
    run_burst(32'h3010, 4'd2, 1'b1, 4'b1000, 32'h7800, 0, 0, 1'b0);
    pulse_reset();

    // Misaligned address.
    run_burst(32'h104, 4'd4, 1'b0, 4'b1000, 32'h8800, 0, 1, 1'b0);

    // Reset after two fill beats discards the partial burst.
    @(negedge clock); drive_idle();
    mem_store_i = 1'b1; mem_addr_i = 32'h200; mem_wrid_i = 4'd5; mem_wseq_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); drive_idle();
      mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_0000 + 32'(i); mem_strb_i = 4'hF;
    end
    pulse_reset();
    run_burst(32'h300, 4'd6, 1'b0, 4'b1000, 32'hC0, 2, 0, 1'b0);

    for (int r = 0; r < 4; r++)
      run_burst($urandom & 32'hFFFF_FFF0, IDW'($urandom), 1'($urandom_range(0, 1)),
                4'b1000, $urandom, $urandom_range(0, 4), $urandom_range(0, 1), 1'b1);

    @(negedge clock); drive_idle();
    #1 check_eq("final_req", 64'(ddr_req_o), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
